// File: rtl/calc_sequencer.sv
// Pocket-calculator control FSM: builds the decimal entry from key events, sequences a
// shared ALU over req/ack, writes the external accumulator and owns error/clear state.
module calc_sequencer #(
  parameter int WIDTH       = 16,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             key_valid_i,
  input  logic [3:0]       key_code_i,
  output logic             key_ready_o,
  output logic             alu_req_o,
  output logic [1:0]       alu_op_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic             alu_ack_i,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_err_i,
  output logic             acc_w_o,
  output logic [WIDTH-1:0] acc_d_o,
  input  logic [WIDTH-1:0] acc_q_i,
  output logic [WIDTH-1:0] disp_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam int CW = (ALU_TIMEOUT > 2) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(ALU_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ALU_WAIT, S_WRITE, S_ERROR} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] entry_q, entry_d;
  logic             digits_q, digits_d;
  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       pend_op_q, pend_op_d;
  logic             err_q, err_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] acc_d_q, acc_d_d;
  logic [CW-1:0]    tmo_q, tmo_d;

  logic             do_clr;
  logic [1:0]       key_op;
  logic [WIDTH-1:0] entry_x10;

  // Key codes 10..13 map onto ALU ops 0..3.
  assign key_op    = key_code_i[1:0] + 2'd2;
  assign entry_x10 = (entry_q << 3) + (entry_q << 1);

  assign key_ready_o = (state_q == S_IDLE) || (state_q == S_ERROR);
  assign alu_req_o   = (state_q == S_ALU_WAIT);
  assign acc_w_o     = (state_q == S_WRITE);
  assign busy_o      = (state_q == S_ALU_WAIT) || (state_q == S_WRITE);
  assign alu_op_o    = alu_op_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign acc_d_o     = acc_d_q;
  assign err_o       = err_q;
  assign disp_o      = digits_q ? entry_q : acc_q_i;

  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    digits_d     = digits_q;
    pend_valid_d = pend_valid_q;
    pend_op_d    = pend_op_q;
    err_d        = err_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    acc_d_d      = acc_d_q;
    tmo_d        = tmo_q;
    do_clr       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_valid_i) begin
          if (key_code_i <= 4'd9) begin
            entry_d  = entry_x10 + {{(WIDTH-4){1'b0}}, key_code_i};
            digits_d = 1'b1;
          end else if (key_code_i == 4'd15) begin
            do_clr = 1'b1;
          end else begin
            entry_d      = '0;
            digits_d     = 1'b0;
            pend_valid_d = (key_code_i != 4'd14);
            pend_op_d    = key_op;
            if (digits_q && !pend_valid_q) begin
              acc_d_d = entry_q;
              state_d = S_WRITE;
            end else if (digits_q) begin
              alu_a_d  = acc_q_i;
              alu_b_d  = entry_q;
              alu_op_d = pend_op_q;
              tmo_d    = '0;
              state_d  = S_ALU_WAIT;
            end
          end
        end
      end
      S_ALU_WAIT: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (alu_ack_i && alu_err_i) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else if (alu_ack_i) begin
          acc_d_d = alu_result_i;
          state_d = S_WRITE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_ERROR: begin
        if (key_valid_i && key_code_i == 4'd15) do_clr = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (do_clr) begin
      entry_d      = '0;
      digits_d     = 1'b0;
      pend_valid_d = 1'b0;
      err_d        = 1'b0;
      acc_d_d      = '0;
      state_d      = S_WRITE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      entry_q      <= '0;
      digits_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_op_q    <= 2'd0;
      err_q        <= 1'b0;
      alu_op_q     <= 2'd0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      acc_d_q      <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      digits_q     <= digits_d;
      pend_valid_q <= pend_valid_d;
      pend_op_q    <= pend_op_d;
      err_q        <= err_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      acc_d_q      <= acc_d_d;
      tmo_q        <= tmo_d;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: a key-level calculator model predicts ALU requests,
// accumulator writes and error entries; a monitor compares them against the DUT outputs.
module tb_calc_sequencer;

  localparam int W   = 16;
  localparam int TMO = 8;
  localparam int K_ADD = 10, K_SUB = 11, K_MUL = 12, K_DIV = 13, K_EQ = 14, K_CLR = 15;
  localparam int M_OK = 0, M_ERR = 1, M_TMO = 2;
  localparam int E_ALU = 0, E_WR = 1, E_ERR = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [3:0]   key_code = 4'd0;
  logic         key_ready, alu_req, alu_ack = 1'b0, alu_err = 1'b0;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_result = '0;
  logic         acc_w, err, busy;
  logic [W-1:0] acc_d, disp;
  logic [W-1:0] acc_reg = '0;

  calc_sequencer #(.WIDTH(W), .ALU_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .key_valid_i(key_valid), .key_code_i(key_code), .key_ready_o(key_ready),
    .alu_req_o(alu_req), .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_ack_i(alu_ack), .alu_result_i(alu_result), .alu_err_i(alu_err),
    .acc_w_o(acc_w), .acc_d_o(acc_d), .acc_q_i(acc_reg),
    .disp_o(disp), .err_o(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // External accumulator register.
  always @(posedge clk) if (acc_w) acc_reg <= acc_d;

  typedef struct {
    int kind;
    int a;
    int b;
    int op;
    int len;
    int data;
  } ev_t;

  ev_t q[$];
  int  n_vec = 0;
  int  n_mis = 0;

  // Calculator model state.
  int m_entry = 0;
  bit m_digits = 0;
  int m_pend = -1;
  int m_acc = 0;
  bit m_err = 0;
  int force_mode = -1;
  int alu_mode_cur = M_OK;
  int alu_delay_cur = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int alu_f(input int a, input int b, input int op);
    longint p;
    p = longint'(a) * longint'(b);
    case (op)
      0:       return (a + b) & 'hFFFF;
      1:       return (a - b) & 'hFFFF;
      2:       return int'(p & 'hFFFF);
      default: return (b == 0) ? 0 : a / b;
    endcase
  endfunction

  function automatic void push_ev(input int kind, input int a, input int b,
                                  input int op, input int len, input int data);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.op = op; e.len = len; e.data = data;
    q.push_back(e);
  endfunction

  function automatic void model_clr();
    m_entry = 0; m_digits = 0; m_pend = -1; m_err = 0; m_acc = 0;
    push_ev(E_WR, 0, 0, 0, 0, 0);
  endfunction

  // Predict the effect of one accepted key.
  function automatic void model_key(input int c);
    int mode, dly, res;
    if (m_err) begin
      if (c == K_CLR) model_clr();
      return;
    end
    if (c <= 9) begin
      m_entry = (m_entry * 10 + c) % 65536;
      m_digits = 1;
    end else if (c == K_CLR) begin
      model_clr();
    end else begin
      if (m_digits && m_pend < 0) begin
        push_ev(E_WR, 0, 0, 0, 0, m_entry);
        m_acc = m_entry;
      end else if (m_digits) begin
        if (force_mode >= 0) begin
          mode = force_mode;
          dly = 2;
        end else begin
          res = $urandom_range(0, 99);
          mode = (res < 8) ? M_ERR : (res < 12) ? M_TMO : M_OK;
          dly = $urandom_range(0, 3);
        end
        if (m_pend == 3 && m_entry == 0 && mode == M_OK) mode = M_ERR;
        alu_mode_cur = mode;
        alu_delay_cur = dly;
        push_ev(E_ALU, m_acc, m_entry, m_pend, (mode == M_TMO) ? TMO : dly + 1, 0);
        if (mode == M_OK) begin
          res = alu_f(m_acc, m_entry, m_pend);
          push_ev(E_WR, 0, 0, 0, 0, res);
          m_acc = res;
        end else begin
          push_ev(E_ERR, 0, 0, 0, 0, 0);
          m_err = 1;
        end
      end
      m_entry = 0;
      m_digits = 0;
      m_pend = (c == K_EQ) ? -1 : c - 10;
    end
  endfunction

  task automatic send_key(input int c);
    int n;
    n = 0;
    @(negedge clk);
    while (!key_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("key_ready_wait", 0, 1);
    end else begin
      key_valid = 1'b1;
      key_code = 4'(c);
      model_key(c);
      @(posedge clk);
      #1 key_valid = 1'b0;
    end
  endtask

  task automatic settle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while ((!key_ready || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_settle"}, int'(n < 100), 1);
    chk({nm, "_disp"}, int'(disp), m_digits ? m_entry : m_acc);
    chk({nm, "_err"}, int'(err), int'(m_err));
  endtask

  task automatic key_seq(input string nm, input int codes[$]);
    foreach (codes[i]) begin
      send_key(codes[i]);
      settle(nm);
    end
  endtask

  // ALU emulation: acks alu_delay_cur cycles into the request, or never in timeout mode.
  initial begin
    bit seen;
    int rc;
    seen = 0;
    rc = 0;
    forever begin
      @(negedge clk);
      alu_ack = 1'b0;
      alu_err = 1'b0;
      if (!rst_n || !alu_req) begin
        seen = 0;
      end else begin
        if (!seen) begin
          seen = 1;
          rc = 0;
        end else begin
          rc++;
        end
        if (alu_mode_cur != M_TMO && rc == alu_delay_cur) begin
          alu_ack = 1'b1;
          alu_err = (alu_mode_cur == M_ERR);
          alu_result = W'(alu_f(int'(alu_a), int'(alu_b), int'(alu_op)));
        end
      end
    end
  end

  task automatic pop_ev(input string nm, output ev_t e, output bit ok);
    n_vec++;
    ok = 0;
    e.kind = -1; e.a = 0; e.b = 0; e.op = 0; e.len = 0; e.data = 0;
    if (q.size() == 0) begin
      n_mis++;
      $display("FAIL %s: got unexpected DUT event, expected none", nm);
    end else begin
      e = q.pop_front();
      ok = 1;
    end
  endtask

  // Monitor: pops expected events whenever the DUT presents a request, write or error.
  initial begin
    ev_t e, cur;
    bit ok, prev_req, prev_err;
    int rlen;
    prev_req = 0;
    prev_err = 0;
    rlen = 0;
    cur.kind = -1; cur.a = 0; cur.b = 0; cur.op = 0; cur.len = 0; cur.data = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 0;
        prev_err = 0;
        continue;
      end
      if (alu_req && !prev_req) begin
        rlen = 0;
        pop_ev("alu_evt", e, ok);
        if (ok) begin
          chk("alu_kind", E_ALU, e.kind);
          cur = e;
        end
        $display("alu req a=%0d b=%0d op=%0d", alu_a, alu_b, alu_op);
      end
      if (alu_req) begin
        rlen++;
        chk("alu_a", int'(alu_a), cur.a);
        chk("alu_b", int'(alu_b), cur.b);
        chk("alu_op", int'(alu_op), cur.op);
        chk("ready_in_wait", int'(key_ready), 0);
        chk("busy_in_wait", int'(busy), 1);
      end
      if (!alu_req && prev_req) chk("req_len", rlen, cur.len);
      if (acc_w) begin
        pop_ev("write_evt", e, ok);
        if (ok) begin
          chk("write_kind", E_WR, e.kind);
          chk("acc_d", int'(acc_d), e.data);
        end
        $display("acc write %0d", acc_d);
      end
      if (err && !prev_err) begin
        pop_ev("error_evt", e, ok);
        if (ok) chk("error_kind", E_ERR, e.kind);
        $display("error entered");
      end
      prev_req = alu_req;
      prev_err = err;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, c;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req", int'(alu_req), 0);
    chk("rst_accw", int'(acc_w), 0);
    chk("rst_accd", int'(acc_d), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(key_ready), 1);
    chk("rst_disp", int'(disp), int'(acc_reg));
    rst_n = 1'b1;

    // Reset pulsed in the middle of an ALU wait.
    force_mode = M_TMO;
    key_seq("t1", '{K_CLR, 1, K_ADD, 2, K_ADD});
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_req_drop", int'(alu_req), 0);
    chk("t1_err", int'(err), 0);
    chk("t1_disp", int'(disp), 1);
    q.delete();
    m_entry = 0; m_digits = 0; m_pend = -1; m_err = 0;
    force_mode = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_ready", int'(key_ready), 1);

    force_mode = M_OK;
    key_seq("t2", '{K_CLR, 1, 2, 3});
    chk("t2_disp123", int'(disp), 123);
    key_seq("t2", '{K_ADD});
    key_seq("t3", '{7, 7, K_EQ});
    chk("t3_disp200", int'(disp), 200);
    key_seq("t4", '{K_CLR, 5, K_ADD, K_SUB, 2, K_EQ});
    chk("t4_disp3", int'(disp), 3);
    key_seq("t5", '{K_CLR, 8, K_DIV, 0, K_EQ, 4});
    chk("t5_err", int'(err), 1);
    chk("t5_disp8", int'(disp), 8);
    key_seq("t5", '{K_CLR});
    chk("t5_clr_err", int'(err), 0);
    force_mode = M_TMO;
    key_seq("t6", '{1, K_ADD, 1, K_EQ});
    chk("t6_err", int'(err), 1);
    force_mode = -1;
    key_seq("t6", '{K_CLR, 7, 0, 0, 0, 0});
    chk("t6_disp4464", int'(disp), 4464);

    // Randomized key stream.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (m_err && $urandom_range(0, 3) == 0) c = K_CLR;
      else if (r < 55) c = $urandom_range(0, 9);
      else if (r < 82) c = $urandom_range(K_ADD, K_DIV);
      else if (r < 95) c = K_EQ;
      else c = K_CLR;
      send_key(c);
      settle("rnd");
    end

    key_seq("end", '{K_CLR});
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
